// File: rtl/up_mem_arbiter_if.sv
// up_mem_arbiter_if: groups the two requester ports (A, B), the single
// memory port and the busy flag of the up_memory arbiter.
// slave  : the arbiter's view (takes requests, drives acks and memory bus)
// master : the surrounding system's view (requesters plus memory)
interface up_mem_arbiter_if;
  // port A (processor core)
  logic       a_req;
  logic       a_we;
  logic [7:0] a_addr;
  logic [7:0] a_wdata;
  logic       a_ack;
  logic [7:0] a_rdata;
  logic       a_wr_err;
  // port B (program loader / debug)
  logic       b_req;
  logic       b_we;
  logic [7:0] b_addr;
  logic [7:0] b_wdata;
  logic       b_ack;
  logic [7:0] b_rdata;
  // memory side
  logic [7:0] mem_addr;
  logic [7:0] mem_in;
  logic       mem_we;
  logic [7:0] mem_out;
  // status
  logic       busy;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  mem_out,
    output a_ack, a_rdata, a_wr_err,
    output b_ack, b_rdata,
    output mem_addr, mem_in, mem_we,
    output busy
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output mem_out,
    input  a_ack, a_rdata, a_wr_err,
    input  b_ack, b_rdata,
    input  mem_addr, mem_in, mem_we,
    input  busy
  );
endinterface

// File: rtl/up_mem_arbiter.sv
// up_mem_arbiter: round-robin arbiter and access sequencer between the
// processor core (port A), the loader/debug port (port B) and the single
// port of the 256x8 up_memory array. One access every three cycles:
// IDLE (arbitrate) -> ACC_x (memory driven from port x) -> DONE (ack).
// Optional feature: define UP_MEM_ARB_WPROT_EN to suppress port A writes
// to addresses 0..PROT_TOP (reported with a_wr_err alongside a_ack).
module up_mem_arbiter #(
  parameter logic [7:0] PROT_TOP = 8'h0F
) (
  input logic              clk,
  input logic              nRst,
  up_mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC_A = 2'd1,
    ACC_B = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state_reg, state_next;
  logic       last_reg, last_next;     // port served most recently: 0 = A, 1 = B
  logic       a_ack_reg, b_ack_reg;
  logic [7:0] a_rdata_reg, b_rdata_reg;
  logic       a_wr_err_reg;
  logic       a_prot;                  // current port A access is a blocked write
  logic [7:0] mem_addr_c, mem_in_c;
  logic       mem_we_c;

`ifdef UP_MEM_ARB_WPROT_EN
  assign a_prot = bus.a_we && (bus.a_addr <= PROT_TOP);
`else
  // Protection disabled: every write passes; the limit is kept only so the
  // parameter list stays identical between builds.
  logic [7:0] unused_prot_top;
  assign unused_prot_top = PROT_TOP;
  assign a_prot          = 1'b0;
`endif

  // State and round-robin pointer register; reset lands in IDLE with B as
  // last served so that A wins the first tie.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_reg <= IDLE;
      last_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
    end
  end

  // Next-state logic: arbitrate only in IDLE; the pointer moves on grant.
  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    case (state_reg)
      IDLE: begin
        if (bus.a_req && (!bus.b_req || last_reg)) begin
          state_next = ACC_A;
          last_next  = 1'b0;
        end else if (bus.b_req) begin
          state_next = ACC_B;
          last_next  = 1'b1;
        end
      end
      ACC_A, ACC_B: state_next = DONE;
      DONE:         state_next = IDLE;
      default:      state_next = IDLE;
    endcase
  end

  // Memory bus mux: driven from the granted port only while in ACC_x.
  always_comb begin
    mem_addr_c = 8'h00;
    mem_in_c   = 8'h00;
    mem_we_c   = 1'b0;
    case (state_reg)
      ACC_A: begin
        mem_addr_c = bus.a_addr;
        mem_in_c   = bus.a_wdata;
        mem_we_c   = bus.a_we && !a_prot;
      end
      ACC_B: begin
        mem_addr_c = bus.b_addr;
        mem_in_c   = bus.b_wdata;
        mem_we_c   = bus.b_we;
      end
      default: ;
    endcase
  end

  // Port A response: capture the combinational read at the end of ACC_A,
  // which for writes is the content before the write edge.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      a_ack_reg    <= 1'b0;
      a_rdata_reg  <= 8'h00;
      a_wr_err_reg <= 1'b0;
    end else if (state_reg == ACC_A) begin
      a_ack_reg    <= 1'b1;
      a_rdata_reg  <= bus.mem_out;
      a_wr_err_reg <= a_prot;
    end else begin
      a_ack_reg    <= 1'b0;
      a_wr_err_reg <= 1'b0;
    end
  end

  // Port B response: same capture, no protection.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      b_ack_reg   <= 1'b0;
      b_rdata_reg <= 8'h00;
    end else if (state_reg == ACC_B) begin
      b_ack_reg   <= 1'b1;
      b_rdata_reg <= bus.mem_out;
    end else begin
      b_ack_reg   <= 1'b0;
    end
  end

  assign bus.a_ack    = a_ack_reg;
  assign bus.a_rdata  = a_rdata_reg;
  assign bus.a_wr_err = a_wr_err_reg;
  assign bus.b_ack    = b_ack_reg;
  assign bus.b_rdata  = b_rdata_reg;
  assign bus.mem_addr = mem_addr_c;
  assign bus.mem_in   = mem_in_c;
  assign bus.mem_we   = mem_we_c;
  assign bus.busy     = (state_reg != IDLE);

endmodule
